// File: rtl/rr_packet_mux.sv
// -----------------------------------------------------------------------------
// rr_packet_mux
//
// Purpose:
//   Packet-level multiplexer that sits downstream of a round-robin arbiter.
//   While idle, it presents the per-channel valid lines to the arbiter as
//   requests. When the arbiter returns a grant for a valid channel, the mux
//   locks onto that channel. It then forwards every beat of that channel's
//   packet through a single registered valid/ready stage until the last beat
//   is accepted. Packets from different channels therefore never interleave.
//
// Optional feature (macro RR_PACKET_MUX_WDOG_EN):
//   Adds a stall watchdog and the wdog_err output. The watchdog counts LOCK
//   cycles in which the owner channel is not valid. When the count reaches
//   WDOG_LIMIT, the lock is abandoned and wdog_err pulses for one cycle.
//   Without the macro, LOCK persists until a last beat transfers.
//
// Parameters:
//   SIZE        number of input channels (>= 2, must match the arbiter)
//   DATA_W      data width per beat
//   WDOG_LIMIT  stall limit in cycles (only used with the watchdog)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel beat valid
//   in_data    per-channel beat data, channel i at [i*DATA_W +: DATA_W]
//   in_last    per-channel last-beat-of-packet flag
//   in_ready   per-channel beat accept (only the owner, only in LOCK)
//   req        request vector to the arbiter (in_valid while idle)
//   gnt        one-hot grant from the arbiter (combinational from req)
//   out_valid  registered output beat valid
//   out_data   registered output beat data
//   out_last   registered output last flag
//   out_ready  consumer accept
//   busy       high while locked to a channel
//   owner      index of the locked channel, 0 when idle
//   wdog_err   one-cycle watchdog pulse (RR_PACKET_MUX_WDOG_EN only)
// -----------------------------------------------------------------------------
module rr_packet_mux #(
  parameter int SIZE       = 4,
  parameter int DATA_W     = 32,
  parameter int WDOG_LIMIT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SIZE-1:0]           in_valid,
  input  logic [SIZE*DATA_W-1:0]    in_data,
  input  logic [SIZE-1:0]           in_last,
  output logic [SIZE-1:0]           in_ready,
  output logic [SIZE-1:0]           req,
  input  logic [SIZE-1:0]           gnt,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [$clog2(SIZE)-1:0]   owner
`ifdef RR_PACKET_MUX_WDOG_EN
  ,
  output logic                      wdog_err
`endif
);

  localparam int OW = $clog2(SIZE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // Index of the lowest set bit. A multi-hot grant still resolves to a
  // single, deterministic owner.
  function automatic logic [OW-1:0] lowest_set(input logic [SIZE-1:0] vec);
    logic [OW-1:0] idx;
    idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = OW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;

  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_last_q;

  logic [SIZE-1:0]     sel_s;
  logic                own_valid_s;
  logic                own_last_s;
  logic [DATA_W-1:0]   own_data_s;
  logic                accept_s;
  logic                xfer_s;
  logic                wdog_hit_s;

  logic [SIZE-1:0]     req_s;
  logic [SIZE-1:0]     in_ready_s;

  // Grant bits for channels that are not valid are ignored.
  assign sel_s = gnt & in_valid;

  // The output stage can take a new beat when it is empty or draining.
  assign accept_s = !out_valid_q || out_ready;

  // Route the owner channel's valid/last/data.
  always_comb begin
    own_valid_s = 1'b0;
    own_last_s  = 1'b0;
    own_data_s  = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (owner_q == OW'(i)) begin
        own_valid_s = in_valid[i];
        own_last_s  = in_last[i];
        own_data_s  = in_data[i*DATA_W +: DATA_W];
      end else begin
        own_valid_s = own_valid_s;
        own_last_s  = own_last_s;
        own_data_s  = own_data_s;
      end
    end
  end

  assign xfer_s = (state_q == ST_LOCK) && own_valid_s && accept_s;

  // ---------------------------------------------------------------------------
  // Optional stall watchdog
  // ---------------------------------------------------------------------------
`ifdef RR_PACKET_MUX_WDOG_EN
  localparam int WCNT_W = ($clog2(WDOG_LIMIT + 1) > 8) ? $clog2(WDOG_LIMIT + 1) : 8;

  logic [WCNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q;
  logic              stall_s;

  assign stall_s = (state_q == ST_LOCK) && !own_valid_s;

  // The hit fires on the stall cycle that would take the count to the limit.
  // As a result, the state drop and the error pulse become visible after exactly
  // WDOG_LIMIT stalled cycles.
  assign wdog_hit_s = stall_s && (wdog_cnt_q == WCNT_W'(WDOG_LIMIT - 1));

  // Stall counter next value. It is held at zero outside LOCK, so every entry
  // to LOCK starts from zero.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (state_q != ST_LOCK) begin
      wdog_cnt_d = '0;
    end else if (xfer_s) begin
      wdog_cnt_d = '0;
    end else if (wdog_hit_s) begin
      wdog_cnt_d = '0;
    end else if (stall_s) begin
      wdog_cnt_d = wdog_cnt_q + WCNT_W'(1);
    end else begin
      wdog_cnt_d = wdog_cnt_q;
    end
  end

  // Stall counter and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_hit_s;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_hit_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // State and locked-owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // Lock on a valid grant and release after the last beat or a watchdog hit.
  // The owner is held at zero whenever the block is idle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_s != '0) begin
          state_d = ST_LOCK;
          owner_d = lowest_set(sel_s);
        end else begin
          state_d = ST_IDLE;
          owner_d = '0;
        end
      end
      ST_LOCK: begin
        if (wdog_hit_s) begin
          state_d = ST_IDLE;
          owner_d = '0;
        end else if (xfer_s && own_last_s) begin
          state_d = ST_IDLE;
          owner_d = '0;
        end else begin
          state_d = ST_LOCK;
          owner_d = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  // Drive arbiter requests while idle, and drive only the owner's ready while locked.
  always_comb begin
    req_s      = '0;
    in_ready_s = '0;
    case (state_q)
      ST_IDLE: begin
        req_s      = in_valid;
        in_ready_s = '0;
      end
      ST_LOCK: begin
        req_s = '0;
        for (int i = 0; i < SIZE; i++) begin
          if (owner_q == OW'(i)) begin
            in_ready_s[i] = accept_s;
          end else begin
            in_ready_s[i] = 1'b0;
          end
        end
      end
      default: begin
        req_s      = '0;
        in_ready_s = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  // Load on a transfer, and clear valid when the consumer drains the stage with
  // nothing new behind it. Data holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (xfer_s) begin
      out_valid_q <= 1'b1;
      out_data_q  <= own_data_s;
      out_last_q  <= own_last_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
      out_data_q  <= out_data_q;
      out_last_q  <= out_last_q;
    end else begin
      out_valid_q <= out_valid_q;
      out_data_q  <= out_data_q;
      out_last_q  <= out_last_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == ST_LOCK);
  assign owner     = owner_q;
  assign req       = req_s;
  assign in_ready  = in_ready_s;

endmodule

// File: doc/rr_packet_mux.md
Name: rr_packet_mux

Overview:
- Downstream companion of the round-robin arbiter.
- Presents per-channel requests to the arbiter and accepts its one-hot grant.
- Locks onto the granted channel for a whole packet and forwards that packet's beats through a registered valid/ready output stage to the shared consumer.
- Guarantees packets from different channels never interleave.

Parameters:
- SIZE, 4, number of input channels; must match the arbiter's SIZE.
- DATA_W, 32, data width per beat.
- WDOG_LIMIT, 255, watchdog stall limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  SIZE  per-channel beat valid.
- in_data  input  SIZE*DATA_W  per-channel beat data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_last  input  SIZE  per-channel last-beat-of-packet flag.
- in_ready  output  SIZE  per-channel beat accept.
- req  output  SIZE  request vector to the arbiter.
- gnt  input  SIZE  one-hot grant from the arbiter, combinational from req.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  output beat data.
- out_last  output  1  output last flag.
- out_ready  input  1  consumer accept.
- busy  output  1  high while locked to a channel.
- owner  output  $clog2(SIZE)  index of the locked channel; 0 when idle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE; owner = 0.
  - out_valid = 0, out_data = 0, out_last = 0.
  - busy = 0.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - req = in_valid; in_ready = 0.
  - sel = gnt & in_valid.
  - If sel != 0: latch owner = index of the lowest set bit of sel, then go to LOCK. This is defensive against a multi-hot gnt.
  - If sel == 0: stay in IDLE. Grant bits for channels that are not valid are ignored.
- LOCK:
  - req = 0.
  - in_ready[owner] = accept, where accept = !out_valid || out_ready. All other in_ready bits = 0.
  - A beat transfers when in_valid[owner] && in_ready[owner].
  - On a transfer: out_data, out_last and out_valid load from the owner channel on the next edge.
  - If the transferred beat has in_last = 1, go to IDLE on that same edge.
  - Owner in_valid may drop mid-packet; the block stays in LOCK.
- Output register:
  - If out_valid && out_ready && no new beat arrives, out_valid clears next cycle.
  - Data holds stable while out_valid && !out_ready.
- Latency and throughput:
  - Grant cycle: 1 cycle, with no data moved.
  - Input accept to out_valid: 1 cycle.
  - Sustained rate: 1 beat/cycle in LOCK while out_ready is high.
  - One bubble between consecutive packets, spent in the IDLE grant cycle.
- Single-beat packet (in_last = 1 on the first beat): LOCK lasts exactly 1 cycle.
- Reset mid-packet: the partial packet is dropped and the output register is cleared. There is no recovery of the beat held in the register.
- owner width: $clog2(SIZE). SIZE must be ≥ 2.

Optional Feature:
- Macro: RR_PACKET_MUX_WDOG_EN.
- When defined:
  - Adds output port wdog_err (1 bit).
  - Adds an 8+ bit stall counter, reset to 0 on every transfer and on entry to LOCK.
  - The counter increments each LOCK cycle in which in_valid[owner] = 0.
  - When the counter reaches WDOG_LIMIT:
    - Force the state to IDLE.
    - Pulse wdog_err high for 1 cycle.
    - Clear the counter.
    - The output register is not touched.
  - wdog_err resets to 0.
- When undefined:
  - No counter and no wdog_err port.
  - LOCK persists indefinitely until a last beat transfers.

Test Plan:
- Reset, then in_valid = 4'b0100 and gnt = 4'b0100 → owner = 2 and busy = 1 on the next cycle. A 3-beat packet 0xA0, 0xA1, 0xA2 (last on 0xA2) with out_ready = 1 appears on out_data on 3 consecutive cycles, each 1 cycle after acceptance; busy = 0 after the last beat.
- Channels 0 and 3 both valid with 2-beat packets, gnt = 4'b1000 → all beats of channel 3 are emitted before any beat of channel 0; in_ready[0] stays 0 throughout LOCK.
- Out_ready held 0 for 5 cycles mid-packet → out_data stable, in_ready[owner] = 0, no beat lost or duplicated after out_ready returns to 1.
- gnt = 4'b0011 (multi-hot) with in_valid = 4'b0011 → owner = 0.
- gnt = 4'b0001 with in_valid = 4'b0010 → stays IDLE, busy = 0.
- Assert rst_n low mid-packet for 1 cycle → out_valid = 0 and busy = 0 immediately, asynchronously. After release, the next grant restarts cleanly.
- With RR_PACKET_MUX_WDOG_EN and WDOG_LIMIT = 8: lock channel 1, then hold in_valid[1] = 0 → wdog_err pulses exactly once after 8 stall cycles, busy drops, and channel 2 can then be granted.
